// File: rtl/radix4_feeder_pkg.sv
// Shared sfp word definitions and the radix-4 twiddle tables for a 16-point FFT.
// sfp word is {sign, exp[3:0], sig[3:0]}, value = (-1)^s * 1.sig * 2^(exp-7); all-zero encodes 0.
package radix4_feeder_pkg;

    localparam int SFP_W     = 9;
    localparam int TW_GROUPS = 4;

    typedef logic [SFP_W-1:0] sfp_t;

    localparam sfp_t SFP_ONE  = 9'h070;
    localparam sfp_t SFP_ZERO = 9'h000;

    // W_16^(k*g): real = cos(2*pi*m/16), imag = -sin(2*pi*m/16), m = k*g
    localparam sfp_t TW_REAL [TW_GROUPS][4] = '{
        '{9'h070, 9'h070, 9'h070, 9'h070},
        '{9'h070, 9'h06E, 9'h067, 9'h058},
        '{9'h070, 9'h067, 9'h000, 9'h167},
        '{9'h070, 9'h058, 9'h167, 9'h16E}
    };

    localparam sfp_t TW_IMAG [TW_GROUPS][4] = '{
        '{9'h000, 9'h000, 9'h000, 9'h000},
        '{9'h000, 9'h158, 9'h167, 9'h16E},
        '{9'h000, 9'h167, 9'h170, 9'h167},
        '{9'h000, 9'h16E, 9'h167, 9'h058}
    };

endpackage

// File: rtl/radix4_twiddle_rom.sv
// Combinational twiddle lookup: (group, lane) -> {real, imag} sfp pair.
module radix4_twiddle_rom
    import radix4_feeder_pkg::*;
#(
    parameter int GROUPS       = 4,
    parameter int FORMAT_WIDTH = 9
) (
    input  logic [$clog2(GROUPS)-1:0] i_group,
    input  logic [1:0]                i_lane,
    output logic [FORMAT_WIDTH-1:0]   o_re,
    output logic [FORMAT_WIDTH-1:0]   o_im
);

    logic [1:0] w_g;
    assign w_g = 2'(i_group);

    always_comb begin
        o_re = FORMAT_WIDTH'(TW_REAL[w_g][i_lane]);
        o_im = FORMAT_WIDTH'(TW_IMAG[w_g][i_lane]);
    end

endmodule

// File: rtl/radix4_feeder.sv
// Collects four complex sfp samples per butterfly group, launches the downstream
// radix-4 butterfly with matching twiddles, and waits (bounded) for its completion.
module radix4_feeder
    import radix4_feeder_pkg::*;
#(
    parameter int EXP_WIDTH    = 4,
    parameter int SIG_WIDTH    = 4,
    parameter int FORMAT_WIDTH = 9,
    parameter int GROUPS       = 4,
    parameter int TIMEOUT      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FORMAT_WIDTH-1:0]       in_real,
    input  logic [FORMAT_WIDTH-1:0]       in_imag,
    input  logic                          hadamard_done,
    output logic                          start,
    output logic [3:0][FORMAT_WIDTH-1:0]  input_real,
    output logic [3:0][FORMAT_WIDTH-1:0]  input_imag,
    output logic [3:0][FORMAT_WIDTH-1:0]  twiddle_real,
    output logic [3:0][FORMAT_WIDTH-1:0]  twiddle_imag,
    output logic [$clog2(GROUPS)-1:0]     group,
    output logic                          frame_done,
    output logic                          timeout_err
);

    localparam int GW = $clog2(GROUPS);
    localparam int CW = $clog2(TIMEOUT + 1);

    if (1 + EXP_WIDTH + SIG_WIDTH != FORMAT_WIDTH) begin : g_fmt_err
        $error("FORMAT_WIDTH must equal 1 + EXP_WIDTH + SIG_WIDTH");
    end

    typedef enum logic [1:0] {COLLECT, ISSUE, WAIT_DONE} state_t;

    state_t                         r_state;
    logic [1:0]                     r_lane;
    logic [GW-1:0]                  r_group;
    logic [CW-1:0]                  r_wait;
    logic                           r_in_ready;
    logic                           r_start;
    logic                           r_frame_done;
    logic                           r_timeout_err;
    logic [3:0][FORMAT_WIDTH-1:0]   r_in_re, r_in_im, r_tw_re, r_tw_im;
    logic [3:0][FORMAT_WIDTH-1:0]   w_tw_re, w_tw_im;
    logic                           w_last_grp;

    for (genvar k = 0; k < 4; k++) begin : g_rom
        radix4_twiddle_rom #(
            .GROUPS       (GROUPS),
            .FORMAT_WIDTH (FORMAT_WIDTH)
        ) u_rom (
            .i_group (r_group),
            .i_lane  (2'(k)),
            .o_re    (w_tw_re[k]),
            .o_im    (w_tw_im[k])
        );
    end

    assign w_last_grp = (r_group == GW'(GROUPS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= COLLECT;
            r_lane        <= '0;
            r_group       <= '0;
            r_wait        <= '0;
            r_in_ready    <= 1'b0;
            r_start       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_in_re       <= '0;
            r_in_im       <= '0;
            r_tw_re       <= '0;
            r_tw_im       <= '0;
        end else begin
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                COLLECT: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_in_re[r_lane] <= in_real;
                        r_in_im[r_lane] <= in_imag;
                        r_lane          <= r_lane + 2'd1;
                        // Twiddles are latched with the last sample so they stay frozen until done.
                        if (r_lane == 2'd3) begin
                            r_state    <= ISSUE;
                            r_start    <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_tw_re    <= w_tw_re;
                            r_tw_im    <= w_tw_im;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= WAIT_DONE;
                    r_wait  <= '0;
                end
                WAIT_DONE: begin
                    // A missed done is treated as completion so the frame keeps moving.
                    if (hadamard_done || (r_wait == CW'(TIMEOUT - 1))) begin
                        if (!hadamard_done) r_timeout_err <= 1'b1;
                        r_state      <= COLLECT;
                        r_in_ready   <= 1'b1;
                        r_wait       <= '0;
                        r_frame_done <= w_last_grp;
                        r_group      <= w_last_grp ? '0 : r_group + GW'(1);
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign start        = r_start;
    assign input_real   = r_in_re;
    assign input_imag   = r_in_im;
    assign twiddle_real = r_tw_re;
    assign twiddle_imag = r_tw_im;
    assign group        = r_group;
    assign frame_done   = r_frame_done;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_radix4_feeder.sv
// Scoreboard bench for radix4_feeder: each driven group pushes its expected launch record.
module tb_radix4_feeder;
    import radix4_feeder_pkg::*;

    localparam int GROUPS  = 4;
    localparam int TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [8:0]      in_real = '0, in_imag = '0;
    logic            hadamard_done = 1'b0;
    logic            start;
    logic [3:0][8:0] input_real, input_imag, twiddle_real, twiddle_imag;
    logic [1:0]      group;
    logic            frame_done, timeout_err;

    typedef struct {
        logic [3:0][8:0] re;
        logic [3:0][8:0] im;
        logic [3:0][8:0] twr;
        logic [3:0][8:0] twi;
        int              grp;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   checks = 0, errors = 0;
    int   exp_group = 0;
    int   push_cnt = 0, start_cnt = 0;

    radix4_feeder #(
        .EXP_WIDTH(4), .SIG_WIDTH(4), .FORMAT_WIDTH(9), .GROUPS(GROUPS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .hadamard_done(hadamard_done),
        .start(start), .input_real(input_real), .input_imag(input_imag),
        .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag),
        .group(group), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts sampled mid-cycle are matched against the oldest pushed group.
    always @(negedge clk) begin
        if (start) begin
            start_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                last_exp = q.pop_front();
                chk("lanes_real", input_real, last_exp.re);
                chk("lanes_imag", input_imag, last_exp.im);
                chk("start_group", group, last_exp.grp);
                chk("tw_real", twiddle_real, last_exp.twr);
                chk("tw_imag", twiddle_imag, last_exp.twi);
                chk("tw_lane0_re", twiddle_real[0], SFP_ONE);
                chk("tw_lane0_im", twiddle_imag[0], SFP_ZERO);
            end
        end
    end

    task automatic send(input logic [8:0] re, input logic [8:0] im);
        int n = 0;
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready_wait", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_group(input logic [8:0] base_re, input logic [8:0] base_im, input int gap);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.re[k]  = base_re + 9'(k);
            e.im[k]  = base_im + 9'(k);
            e.twr[k] = TW_REAL[exp_group][k];
            e.twi[k] = TW_IMAG[exp_group][k];
        end
        e.grp = exp_group;
        q.push_back(e);
        push_cnt++;
        for (int k = 0; k < 4; k++) begin
            send(e.re[k], e.im[k]);
            if (k < 3) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic advance_model(output bit fd);
        fd = (exp_group == GROUPS - 1);
        exp_group = (exp_group + 1) % GROUPS;
    endtask

    task automatic finish_group(input int dly, input logic exp_err);
        bit fd;
        repeat (dly) @(negedge clk);
        chk("hold_in_real", input_real, last_exp.re);
        chk("hold_tw_real", twiddle_real, last_exp.twr);
        chk("hold_tw_imag", twiddle_imag, last_exp.twi);
        hadamard_done = 1'b1;
        @(negedge clk);
        hadamard_done = 1'b0;
        advance_model(fd);
        chk("done_group", group, exp_group);
        chk("done_frame_done", frame_done, fd);
        chk("done_in_ready", in_ready, 1);
        chk("done_timeout_err", timeout_err, exp_err);
        @(negedge clk);
        chk("frame_done_pulse", frame_done, 0);
    endtask

    initial begin
        bit fd;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_start", start, 0);
        chk("rst_group", group, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_lanes", input_real, 0);
        rst = 1'b1;

        // Back-to-back group 0
        send_group(9'h101, 9'h1F1, 0);
        chk("issue_in_ready", in_ready, 0);
        chk("issue_start", start, 1);
        @(negedge clk);
        chk("start_one_cycle", start, 0);
        finish_group(4, 1'b0);

        // Remaining groups of the frame, done five cycles after each start
        for (int g = 1; g < GROUPS; g++) begin
            send_group(9'(9'h010 * g + 9'h005), 9'(9'h020 * g + 9'h003), 0);
            finish_group(5, 1'b0);
        end

        // in_valid toggling every other cycle
        send_group(9'h0A0, 9'h0B0, 1);
        finish_group(5, 1'b0);

        // Missing done: timeout
        send_group(9'h0C0, 9'h0D0, 0);
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
            if (n == TIMEOUT) chk("timeout_not_early", timeout_err, 0);
        end
        advance_model(fd);
        chk("timeout_cycles", n, TIMEOUT + 1);
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_group", group, exp_group);
        chk("timeout_frame_done", frame_done, fd);

        // Stray done during COLLECT and ISSUE
        begin
            exp_t e;
            for (int k = 0; k < 4; k++) begin
                e.re[k]  = 9'h140 + 9'(k);
                e.im[k]  = 9'h150 + 9'(k);
                e.twr[k] = TW_REAL[exp_group][k];
                e.twi[k] = TW_IMAG[exp_group][k];
            end
            e.grp = exp_group;
            q.push_back(e);
            push_cnt++;
            send(e.re[0], e.im[0]);
            send(e.re[1], e.im[1]);
            hadamard_done = 1'b1;
            @(negedge clk);
            hadamard_done = 1'b0;
            chk("stray_in_ready", in_ready, 1);
            chk("stray_group", group, exp_group);
            chk("stray_no_start", start, 0);
            send(e.re[2], e.im[2]);
            send(e.re[3], e.im[3]);
            hadamard_done = 1'b1;
            @(negedge clk);
            hadamard_done = 1'b0;
            chk("issue_done_ignored", in_ready, 0);
            chk("issue_done_group", group, exp_group);
            finish_group(4, 1'b1);
        end

        // Reset after three accepts
        send(9'h111, 9'h122);
        send(9'h112, 9'h123);
        send(9'h113, 9'h124);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_group", group, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        chk("midrst_lanes_re", input_real, 0);
        chk("midrst_lanes_im", input_imag, 0);
        chk("midrst_tw", twiddle_real, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_group = 0;
        send_group(9'h1A1, 9'h0E1, 0);
        finish_group(5, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("start_count", start_cnt, push_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
